// File: rtl/normalization_scheduler.sv
// Round-robin owner of a shared matrix normalization engine: grants one requester,
// pulses the engine start, then acks on done or aborts the engine on watchdog expiry.
module normalization_scheduler #(
  parameter int          NUM_REQ        = 4,
  parameter int          TIMEOUT_CYCLES = 1024,
  parameter logic [15:0] JOBS_INIT      = 16'h0000,  // reset value of jobs_done; 0 in normal use
  parameter int          IDX_W          = $clog2(NUM_REQ),
  parameter int          CNT_W          = $clog2(TIMEOUT_CYCLES + 1)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NUM_REQ-1:0] req,
  output logic [NUM_REQ-1:0] grant,
  output logic [IDX_W-1:0]   grant_idx,
  output logic               busy,
  output logic               norm_start,
  input  logic               norm_done,
  output logic               norm_reset,
  output logic [NUM_REQ-1:0] ack,
  output logic [NUM_REQ-1:0] err,
  output logic [15:0]        jobs_done,
  output logic [2:0]         state_dbg
);

  // Handshake: req is a level held by the requester until it sees its one-cycle ack or err;
  // norm_start/norm_done/norm_reset are single-cycle pulses with no back-pressure.

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    SETUP   = 3'd1,
    START   = 3'd2,
    WAIT    = 3'd3,
    ACK     = 3'd4,
    RECOVER = 3'd5
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [IDX_W-1:0] rr_ptr;
  logic [CNT_W-1:0] watchdog;
  logic             pick_found;
  logic [IDX_W-1:0] pick_idx;
  int               probe;

  assign state_dbg = state;

  // First set request at or above rr_ptr, wrapping around.
  always_comb begin
    pick_found = 1'b0;
    pick_idx   = '0;
    probe      = 0;
    for (int i = 0; i < NUM_REQ; i++) begin
      probe = int'(rr_ptr) + i;
      if (probe >= NUM_REQ) probe = probe - NUM_REQ;
      if (!pick_found && req[probe]) begin
        pick_found = 1'b1;
        pick_idx   = IDX_W'(probe);
      end
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (pick_found) state_nxt = SETUP;
      SETUP:   state_nxt = START;
      START:   state_nxt = WAIT;
      WAIT: begin
        if (norm_done)                                      state_nxt = ACK;
        else if (watchdog == CNT_W'(TIMEOUT_CYCLES - 1))    state_nxt = RECOVER;
      end
      ACK:     state_nxt = IDLE;
      RECOVER: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Outputs are decoded from the next state so every pulse is a flop output.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      rr_ptr     <= '0;
      watchdog   <= '0;
      grant      <= '0;
      grant_idx  <= '0;
      busy       <= 1'b0;
      norm_start <= 1'b0;
      norm_reset <= 1'b0;
      ack        <= '0;
      err        <= '0;
      jobs_done  <= JOBS_INIT;
    end else begin
      state      <= state_nxt;
      busy       <= (state_nxt != IDLE);
      norm_start <= (state_nxt == START);
      norm_reset <= (state_nxt == RECOVER);
      ack        <= (state_nxt == ACK)     ? grant : '0;
      err        <= (state_nxt == RECOVER) ? grant : '0;

      if (state == IDLE && pick_found) begin
        grant     <= NUM_REQ'(1) << pick_idx;
        grant_idx <= pick_idx;
      end else if (state_nxt == IDLE) begin
        grant <= '0;
      end

      if (state == START)     watchdog <= '0;
      else if (state == WAIT) watchdog <= watchdog + CNT_W'(1);

      if (state_nxt == ACK && jobs_done != 16'hFFFF) jobs_done <= jobs_done + 16'd1;

      if (state == ACK || state == RECOVER)
        rr_ptr <= (grant_idx == IDX_W'(NUM_REQ - 1)) ? '0 : grant_idx + IDX_W'(1);
    end
  end

endmodule

// File: tb/tb_normalization_scheduler.sv
// Bench for normalization_scheduler: two instances (nominal watchdog, and a short watchdog with
// jobs_done starting near saturation) steered by sel, checked against a per-instance arbitration model.
module tb_normalization_scheduler;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] req;
  logic       norm_done;
  logic       sel;

  logic [3:0] req_a, req_b;
  logic       done_a, done_b;
  logic [3:0] grant_a, ack_a, err_a, grant_b, ack_b, err_b;
  logic [1:0] idx_a, idx_b;
  logic       busy_a, start_a, nrst_a, busy_b, start_b, nrst_b;
  logic [15:0] jobs_a, jobs_b;
  logic [2:0] st_a, st_b;

  logic [3:0]  grant, ack, err;
  logic [1:0]  grant_idx;
  logic        busy, norm_start, norm_reset;
  logic [15:0] jobs_done;

  int          checks   = 0;
  int          failures = 0;
  int          m_ptr [2];
  logic [15:0] m_jobs[2];

  assign req_a  = sel ? 4'b0000 : req;
  assign req_b  = sel ? req : 4'b0000;
  assign done_a = sel ? 1'b0 : norm_done;
  assign done_b = sel ? norm_done : 1'b0;

  assign grant      = sel ? grant_b : grant_a;
  assign ack        = sel ? ack_b   : ack_a;
  assign err        = sel ? err_b   : err_a;
  assign grant_idx  = sel ? idx_b   : idx_a;
  assign busy       = sel ? busy_b  : busy_a;
  assign norm_start = sel ? start_b : start_a;
  assign norm_reset = sel ? nrst_b  : nrst_a;
  assign jobs_done  = sel ? jobs_b  : jobs_a;

  normalization_scheduler dut_a (
    .clk(clk), .reset(reset), .req(req_a), .grant(grant_a), .grant_idx(idx_a), .busy(busy_a),
    .norm_start(start_a), .norm_done(done_a), .norm_reset(nrst_a), .ack(ack_a), .err(err_a),
    .jobs_done(jobs_a), .state_dbg(st_a)
  );

  normalization_scheduler #(.TIMEOUT_CYCLES(16), .JOBS_INIT(16'hFFFD)) dut_b (
    .clk(clk), .reset(reset), .req(req_b), .grant(grant_b), .grant_idx(idx_b), .busy(busy_b),
    .norm_start(start_b), .norm_done(done_b), .norm_reset(nrst_b), .ack(ack_b), .err(err_b),
    .jobs_done(jobs_b), .state_dbg(st_b)
  );

  // clock / time guard
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL time_guard observed=expired expected=finish");
    $fatal(1, "time guard expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int pick(input logic [3:0] r, input int ptr);
    for (int i = 0; i < 4; i++) begin
      if (r[(ptr + i) % 4]) return (ptr + i) % 4;
    end
    return 0;
  endfunction

  // dly: cycles after the start cycle at which the engine pulses done (0 = never).
  task automatic run_job(input logic [3:0] r, input int dly, input bit drop_after_grant,
                         input bit done_in_setup, input bit drop_all);
    int         exp_idx, to, k_end, exp_end, starts;
    bit         exp_ack;
    logic [3:0] oh;
    to      = sel ? 16 : 1024;
    exp_idx = pick(r, m_ptr[sel]);
    oh      = 4'b0001 << exp_idx;
    exp_ack = (dly >= 1 && dly <= to);
    exp_end = exp_ack ? dly + 1 : to + 1;
    req = r;
    @(negedge clk);
    check("grant", grant, oh);
    check("grant_idx", grant_idx, exp_idx);
    check("busy", busy, 1);
    check("start_early", norm_start, 0);
    if (drop_after_grant) req = 4'b0000;
    if (done_in_setup) norm_done = 1'b1;
    @(negedge clk);
    norm_done = 1'b0;
    check("start", norm_start, 1);
    check("grant_at_start", grant, oh);
    k_end  = -1;
    starts = 0;
    for (int k = 1; k <= to + 4; k++) begin
      @(negedge clk);
      norm_done = 1'b0;
      if ((ack | err) != 4'b0000 || norm_reset) begin
        k_end = k;
        break;
      end
      if (norm_start) starts++;
      if (k == dly) norm_done = 1'b1;
    end
    check("extra_start", starts, 0);
    check("end_cycle", k_end, exp_end);
    check("ack", ack, exp_ack ? oh : 4'b0000);
    check("err", err, exp_ack ? 4'b0000 : oh);
    check("norm_reset", norm_reset, !exp_ack);
    check("grant_hold", grant, oh);
    if (exp_ack && m_jobs[sel] != 16'hFFFF) m_jobs[sel] = m_jobs[sel] + 16'd1;
    m_ptr[sel] = (exp_idx + 1) % 4;
    if (drop_all) req = 4'b0000;
    else          req = req & ~oh;
    @(negedge clk);
    check("grant_clr", grant, 0);
    check("busy_idle", busy, 0);
    check("idx_keep", grant_idx, exp_idx);
    check("jobs_done", jobs_done, m_jobs[sel]);
    check("pulses_clr", {ack, err, norm_reset, norm_start}, 0);
  endtask

  initial begin
    reset = 1'b0; req = 4'b0000; norm_done = 1'b0; sel = 1'b0;
    m_ptr[0] = 0; m_ptr[1] = 0; m_jobs[0] = 16'h0000; m_jobs[1] = 16'hFFFD;
    repeat (3) @(negedge clk);
    check("reset_outs_a", {grant_a, idx_a, busy_a, start_a, nrst_a, ack_a, err_a}, 0);
    check("reset_jobs_a", jobs_a, 16'h0000);
    check("reset_jobs_b", jobs_b, 16'hFFFD);
    reset = 1'b1;
    @(negedge clk);
    check("idle_outs_a", {grant_a, busy_a, start_a, nrst_a, ack_a, err_a}, 0);

    // rotation with all requesters held, each re-raising after its ack
    for (int n = 0; n < 5; n++) run_job(4'b1111, 4 + n, 1'b0, 1'b0, 1'b0);
    // single requester, engine done 203 cycles after start
    run_job(4'b0010, 203, 1'b0, 1'b0, 1'b1);

    // done pulses in IDLE and in SETUP are ignored
    norm_done = 1'b1;
    @(negedge clk);
    norm_done = 1'b0;
    check("idle_done_busy", busy, 0);
    check("idle_done_ack", ack, 0);
    @(negedge clk);
    check("idle_done_jobs", jobs_done, m_jobs[0]);
    check("idle_done_grant", grant, 0);
    run_job(4'b0001, 30, 1'b1, 1'b1, 1'b1);

    for (int n = 0; n < 8; n++)
      run_job(4'($urandom_range(1, 15)), $urandom_range(1, 300), 1'($urandom_range(0, 1)), 1'b0, 1'b1);

    // asynchronous reset in the middle of WAIT
    req = 4'b0100;
    repeat (7) @(negedge clk);
    #2 reset = 1'b0;
    #1;
    check("mid_reset_outs", {grant_a, idx_a, busy_a, start_a, nrst_a, ack_a, err_a}, 0);
    check("mid_reset_jobs", jobs_a, 16'h0000);
    m_ptr[0] = 0; m_ptr[1] = 0; m_jobs[0] = 16'h0000; m_jobs[1] = 16'hFFFD;
    req = 4'b1001;
    @(negedge clk);
    reset = 1'b1;
    run_job(4'b1001, 12, 1'b0, 1'b0, 1'b1);

    // short-watchdog instance: timeout, boundary done, saturation
    sel = 1'b1;
    @(negedge clk);
    run_job(4'b0100, 0, 1'b0, 1'b0, 1'b1);
    run_job(4'b1011, 5, 1'b0, 1'b0, 1'b1);
    run_job(4'b0001, 16, 1'b0, 1'b0, 1'b1);
    run_job(4'b0010, 3, 1'b0, 1'b0, 1'b1);
    run_job(4'b0100, 17, 1'b0, 1'b0, 1'b1);
    for (int n = 0; n < 30; n++)
      run_job(4'($urandom_range(1, 15)), $urandom_range(0, 20), 1'($urandom_range(0, 1)), 1'b0, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
